// File: rtl/puf_net_pkg.sv
// puf_net_pkg: shared definitions for the PUF XOR / vote / pack datapath.
//   state_e         - packer FSM state encoding (collect = 0, output = 1)
//   DefaultVoteW    - default width of the repetition config and vote counters
//   unstable_width  - width needed to count 0..out_w unstable bits
package puf_net_pkg;

    typedef enum logic {
        StCollect = 1'b0,
        StOutput  = 1'b1
    } state_e;

    localparam int unsigned DefaultVoteW = 4;

    function automatic int unsigned unstable_width(input int unsigned out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/puf_xor_vote_packer_if.sv
// puf_xor_vote_packer_if: configuration, input stream and output stream of the packer.
//   cfg_xor_mask / cfg_reps          - runtime XOR subset and repetitions per voted bit
//   in_valid / in_ready / in_response - one raw PUF evaluation per accepted beat
//   out_valid / out_ready / out_word / out_unstable - packed voted word and unstable count
// Modports: slave = packer side, master = producer/consumer side.
interface puf_xor_vote_packer_if
    import puf_net_pkg::*;
#(
    parameter int unsigned NUM_PUF = 6,
    parameter int unsigned VOTE_W  = DefaultVoteW,
    parameter int unsigned OUT_W   = 32
);
    localparam int unsigned UnstW = unstable_width(OUT_W);

    logic [NUM_PUF-1:0] cfg_xor_mask;
    logic [VOTE_W-1:0]  cfg_reps;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_PUF-1:0] in_response;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_word;
    logic [UnstW-1:0]   out_unstable;

    modport slave (
        input  cfg_xor_mask,
        input  cfg_reps,
        input  in_valid,
        input  in_response,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output out_unstable
    );

    modport master (
        output cfg_xor_mask,
        output cfg_reps,
        output in_valid,
        output in_response,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  out_unstable
    );

endinterface

// File: rtl/puf_xor_reduce.sv
// puf_xor_reduce: combinational parity of the masked PUF response bits.
//   resp_i   - raw response bits of one evaluation
//   mask_i   - 1 = bit participates in the XOR
//   parity_o - XOR of the participating bits (0 for an all-zero mask)
module puf_xor_reduce #(
    parameter int unsigned NUM_PUF = 6
) (
    input  logic [NUM_PUF-1:0] resp_i,
    input  logic [NUM_PUF-1:0] mask_i,
    output logic               parity_o
);

    assign parity_o = ^(resp_i & mask_i);

endmodule

// File: rtl/puf_xor_vote_packer.sv
// puf_xor_vote_packer: XORs a selectable subset of PUF response bits, majority-votes each
// XOR bit over cfg_reps evaluations and packs OUT_W voted bits into one output word along
// with the count of non-unanimous bits.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; discards any partial or pending word
//   bus   - slave modport: config, input evaluation stream, output word stream
module puf_xor_vote_packer
    import puf_net_pkg::*;
#(
    parameter int unsigned NUM_PUF = 6,
    parameter int unsigned VOTE_W  = DefaultVoteW,
    parameter int unsigned OUT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    puf_xor_vote_packer_if.slave  bus
);

    localparam int unsigned BitW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned UnstW = unstable_width(OUT_W);

    state_e             state_q, state_d;
    logic [VOTE_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [VOTE_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic [VOTE_W-1:0]  reps_q, reps_d;
    logic [NUM_PUF-1:0] mask_q, mask_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0]   word_q, word_d;
    logic [UnstW-1:0]   unst_q, unst_d;

    logic               word_start;
    logic [VOTE_W-1:0]  reps_live;
    logic [VOTE_W-1:0]  reps_eff;
    logic [NUM_PUF-1:0] mask_eff;
    logic               in_ready;
    logic               accept;
    logic               parity;
    logic [VOTE_W-1:0]  ones_new;
    logic [VOTE_W-1:0]  rep_new;
    logic               vote_done;
    logic               vote_bit;
    logic               vote_unstable;
    logic               last_bit;

    // First beat of a word: config is sampled live here and frozen until the word ends.
    assign word_start = (state_q == StCollect) && (rep_cnt_q == '0) && (bit_cnt_q == '0);
    assign reps_live  = (bus.cfg_reps == '0) ? VOTE_W'(1) : bus.cfg_reps;
    assign reps_eff   = word_start ? reps_live : reps_q;
    assign mask_eff   = word_start ? bus.cfg_xor_mask : mask_q;

    assign in_ready = (state_q == StCollect) && !reset;
    assign accept   = bus.in_valid && in_ready;

    puf_xor_reduce #(
        .NUM_PUF (NUM_PUF)
    ) u_xor_reduce (
        .resp_i   (bus.in_response),
        .mask_i   (mask_eff),
        .parity_o (parity)
    );

    // rep_cnt_q < reps_eff always holds in collect, so neither sum can overflow.
    assign ones_new  = ones_cnt_q + VOTE_W'(parity);
    assign rep_new   = rep_cnt_q + VOTE_W'(1);
    assign vote_done = accept && (rep_new == reps_eff);

    // Strict majority; an even split votes 0.
    assign vote_bit      = {ones_new, 1'b0} > {1'b0, reps_eff};
    assign vote_unstable = (ones_new != '0) && (ones_new != reps_eff);
    assign last_bit      = (bit_cnt_q == BitW'(OUT_W - 1));

    always_comb begin
        state_d    = state_q;
        rep_cnt_d  = rep_cnt_q;
        ones_cnt_d = ones_cnt_q;
        reps_d     = reps_q;
        mask_d     = mask_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        unst_d     = unst_q;

        if (word_start) begin
            mask_d = bus.cfg_xor_mask;
            reps_d = reps_live;
        end

        case (state_q)
            StCollect: begin
                if (accept) begin
                    if (vote_done) begin
                        rep_cnt_d         = '0;
                        ones_cnt_d        = '0;
                        word_d[bit_cnt_q] = vote_bit;
                        unst_d            = unst_q + UnstW'(vote_unstable);
                        if (last_bit) begin
                            bit_cnt_d = '0;
                            state_d   = StOutput;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        rep_cnt_d  = rep_new;
                        ones_cnt_d = ones_new;
                    end
                end
            end
            StOutput: begin
                if (bus.out_ready) begin
                    word_d  = '0;
                    unst_d  = '0;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StCollect;
            rep_cnt_q  <= '0;
            ones_cnt_q <= '0;
            reps_q     <= VOTE_W'(1);
            mask_q     <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            unst_q     <= '0;
        end else begin
            state_q    <= state_d;
            rep_cnt_q  <= rep_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            reps_q     <= reps_d;
            mask_q     <= mask_d;
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            unst_q     <= unst_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = (state_q == StOutput);
    assign bus.out_word     = word_q;
    assign bus.out_unstable = unst_q;

endmodule

// File: doc/puf_xor_vote_packer.md
# puf_xor_vote_packer

Parametrised successor to the six-input PUF output XOR. It takes NUM_PUF arbiter response bits per challenge evaluation and XORs a runtime-selectable subset of them. It majority-votes each XOR bit over a configurable number of repeated evaluations, packs the voted bits into an OUT_W-bit word, and presents that word with a count of unstable (non-unanimous) bits over a valid/ready handshake. It sits between the PUF instance array and the response FIFO/host interface.

## Interface
Parameters:
- NUM_PUF, 6, number of PUF response bits per evaluation
- VOTE_W, 4, width of repetition config and vote counters (max 2^VOTE_W−1 repetitions)
- OUT_W, 32, voted bits per output word

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- cfg_xor_mask  in  NUM_PUF  1 = response bit participates in XOR
- cfg_reps  in  VOTE_W  evaluations per voted bit; 0 treated as 1
- in_valid  in  1  in_response valid
- in_ready  out  1  block accepts in_response this cycle
- in_response  in  NUM_PUF  one evaluation's raw PUF bits
- out_valid  out  1  out_word/out_unstable valid
- out_ready  in  1  consumer accepts word
- out_word  out  OUT_W  voted bits; bit i = i-th voted bit of the word
- out_unstable  out  $clog2(OUT_W+1)  number of non-unanimous bits in out_word

## Operation
- States: COLLECT, OUTPUT. Reset → COLLECT with rep_cnt, ones_cnt, bit_cnt, out_word, out_unstable = 0 and out_valid = 0.
- in_ready = (state == COLLECT) && !reset. out_valid = (state == OUTPUT).
- Config latch: cfg_xor_mask and reps_eff = (cfg_reps == 0 ? 1 : cfg_reps) are registered every cycle in which state == COLLECT, rep_cnt == 0 and bit_cnt == 0. The accept in that cycle uses the live inputs. Config is frozen for the rest of the word.
- Accept (in_valid && in_ready):
  - x = ^(in_response & mask).
  - ones_cnt += x; rep_cnt += 1.
- Vote: when the accept makes rep_cnt reach reps_eff:
  - out_word[bit_cnt] ← (2·ones_new > reps_eff), compared at VOTE_W+1 bits; an even-count tie gives 0.
  - out_unstable += (ones_new != 0 && ones_new != reps_eff).
  - rep_cnt and ones_cnt clear; bit_cnt += 1.
- Word done: when the vote writes bit OUT_W−1, bit_cnt clears and state → OUTPUT.
- OUTPUT: out_word and out_unstable are held stable until out_valid && out_ready. On that handshake:
  - out_word and out_unstable clear.
  - state → COLLECT.
- An all-zero mask gives x = 0: every bit votes 0 and unstable stays 0.
- Reset mid-word or mid-OUTPUT discards the partial or pending word. There is no flush output.

## Timing
- out_valid rises the cycle after the accept that completes bit OUT_W−1.
- Minimum word period = OUT_W·reps_eff accepts + 1 OUTPUT cycle.
- With out_ready held high, OUTPUT lasts exactly one cycle and in_ready returns 1 the next cycle. There is no combinational path from out_ready to in_ready.
- in_valid while in_ready = 0 is ignored, with no backpressure latch. The upstream holds its data per valid/ready rules.
- Throughput: 1 evaluation/cycle in COLLECT, no bubbles between bits.

## Structure
- Shared package puf_net_pkg:
  - state encoding (COLLECT = 0, OUTPUT = 1)
  - default VOTE_W
  - function computing the out_unstable width
- Sub-module puf_xor_reduce: combinational masked parity, NUM_PUF-parametrised, instantiated once.
- Top holds the FSM, counters and output registers. Target is 150–250 lines.

## Test plan
- NUM_PUF=6, mask=6'h3F, reps=1, 32 accepts, each response with popcount parity = i%2 → out_word=32'hAAAAAAAA, out_unstable=0, out_valid the cycle after the 32nd accept.
- reps=3, each bit fed votes (1,1,0) → out_word=32'hFFFFFFFF, out_unstable=32. Votes (1,0,0) → 32'h0, out_unstable=32.
- reps=4, votes (1,1,0,0) for every bit → tie gives 0: out_word=0, out_unstable=32. cfg_reps=0 behaves exactly as reps=1.
- mask=6'h01 with response=6'h3E (bit0 = 0) → all bits 0. Change mask mid-word → no effect until the next word.
- Hold out_ready=0 for 10 cycles in OUTPUT → out_word stable, in_ready=0, in_valid pulses ignored. Release → one-cycle handshake, then collection resumes.
- Assert reset at bit 17 and again during OUTPUT → next cycle out_valid=0, out_word=0, in_ready=1 after reset deasserts, and the next word is built from scratch.
